// File: rtl/cc_sdi_pkg.sv
// Shared types and constants for the cell-controller SDI receive-side blocks.
package cc_sdi_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] IDX_POS_X = 8'd0;
  localparam logic [7:0] IDX_POS_Y = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] seq_next(input logic [DATA_W-1:0] v);
    return v + DATA_W'(1);
  endfunction

endpackage

// File: rtl/cc_sat_cnt.sv
// Saturating up-counter: holds at all-ones, clears on synchronous reset.
module cc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/cc_countdatachk.sv
// SDI local-data burst checker: per FA trigger, extracts X/Y position and checks count sequence and length.
// CC_SEQ_CHECK_EN builds the +1 count-sequence comparator and seqErrCnt; otherwise seqErrCnt is tied to 0.
module cc_countdatachk
  import cc_sdi_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TO_W  = 16
) (
  input  logic              sdi_clk,
  input  logic              Reset,
  input  logic              fa_evr_trig,
  input  logic [7:0]        expCount,
  input  logic [TO_W-1:0]   timeoutCycles,
  input  logic              RxDataValid,
  input  logic [DATA_W-1:0] RxCountData,
  input  logic [DATA_W-1:0] RxBpmPosData,
  output logic [DATA_W-1:0] RxPosX,
  output logic [DATA_W-1:0] RxPosY,
  output logic              PosValid,
  output logic              FrameDone,
  output logic              FrameErr,
  output logic [31:0]       frameCnt,
  output logic [CNT_W-1:0]  seqErrCnt,
  output logic [CNT_W-1:0]  lenErrCnt,
  output logic [CNT_W-1:0]  timeoutCnt,
  output logic [7:0]        lastLen,
  output logic              busy
);

  localparam logic [7:0] IDX_MAX = 8'hFF;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] shadow_x_q, shadow_x_d;
  logic [DATA_W-1:0] pos_x_q, pos_x_d;
  logic [DATA_W-1:0] pos_y_q, pos_y_d;
  logic              pos_vld_q, pos_vld_d;
  logic              abort_q, abort_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        last_len_q, last_len_d;

  logic in_frame;
  logic accept;
  logic timeout_hit;
  logic len_bad;
  logic seq_bad;

  assign in_frame    = (state_q == ST_WAIT) || (state_q == ST_RECV);
  // A trigger inside a frame takes priority; the word in that cycle is dropped.
  assign accept      = RxDataValid && !fa_evr_trig && in_frame;
  assign timeout_hit = (state_q == ST_WAIT) && !fa_evr_trig && !RxDataValid &&
                       (to_cnt_q == timeoutCycles);
  assign len_bad     = (state_q == ST_DONE) && (expCount != 8'd0) && (idx_q != expCount);

`ifdef CC_SEQ_CHECK_EN
  logic [DATA_W-1:0] ref_q;

  assign seq_bad = accept && (state_q == ST_RECV) && (RxCountData != seq_next(ref_q));

  always_ff @(posedge sdi_clk) begin
    if (Reset)
      ref_q <= '0;
    else if (accept)
      ref_q <= RxCountData;
  end

  cc_sat_cnt #(.W(CNT_W)) u_seq_err (
    .clk (sdi_clk),
    .rst (Reset),
    .inc (seq_bad),
    .q   (seqErrCnt)
  );
`else
  logic unused_cnt;

  assign unused_cnt = ^RxCountData;
  assign seq_bad    = 1'b0;
  assign seqErrCnt  = '0;
`endif

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    shadow_x_d  = shadow_x_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    pos_vld_d   = 1'b0;
    abort_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    last_len_d  = last_len_q;

    case (state_q)
      ST_WAIT: begin
        if (accept) begin
          state_d    = ST_RECV;
          idx_d      = IDX_POS_X + 8'd1;
          shadow_x_d = RxBpmPosData;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (idx_q != IDX_MAX)
            idx_d = idx_q + 8'd1;
          if (idx_q == IDX_POS_Y) begin
            pos_x_d   = shadow_x_q;
            pos_y_d   = RxBpmPosData;
            pos_vld_d = 1'b1;
          end
          if (seq_bad)
            err_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_len_d  = idx_q;
        frame_cnt_d = frame_cnt_q + 32'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Any trigger starts a fresh frame in WAIT; inside WAIT/RECV it also aborts the current one.
    if (fa_evr_trig) begin
      state_d  = ST_WAIT;
      to_cnt_d = '0;
      idx_d    = '0;
      err_d    = 1'b0;
      abort_d  = in_frame;
    end
  end

  always_ff @(posedge sdi_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      shadow_x_q  <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_vld_q   <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
      last_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      shadow_x_q  <= shadow_x_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      pos_vld_q   <= pos_vld_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
      last_len_q  <= last_len_d;
    end
  end

  cc_sat_cnt #(.W(CNT_W)) u_len_err (
    .clk (sdi_clk),
    .rst (Reset),
    .inc (len_bad || (fa_evr_trig && in_frame)),
    .q   (lenErrCnt)
  );

  cc_sat_cnt #(.W(CNT_W)) u_timeout (
    .clk (sdi_clk),
    .rst (Reset),
    .inc (timeout_hit),
    .q   (timeoutCnt)
  );

  assign RxPosX    = pos_x_q;
  assign RxPosY    = pos_y_q;
  assign PosValid  = pos_vld_q;
  assign FrameDone = (state_q == ST_DONE) || abort_q;
  assign FrameErr  = ((state_q == ST_DONE) && (err_q || len_bad)) || abort_q;
  assign frameCnt  = frame_cnt_q;
  assign lastLen   = last_len_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cc_countdatachk.sv
// Scoreboard bench for cc_countdatachk: stimulus pushes expected PosValid/FrameDone events, a monitor pops them.
module tb_cc_countdatachk;

  localparam int CNT_W = 4;
  localparam int TO_W  = 16;
`ifdef CC_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic             sdi_clk = 1'b0;
  logic             Reset;
  logic             fa_evr_trig;
  logic [7:0]       expCount;
  logic [TO_W-1:0]  timeoutCycles;
  logic             RxDataValid;
  logic [31:0]      RxCountData;
  logic [31:0]      RxBpmPosData;
  logic [31:0]      RxPosX, RxPosY;
  logic             PosValid, FrameDone, FrameErr;
  logic [31:0]      frameCnt;
  logic [CNT_W-1:0] seqErrCnt, lenErrCnt, timeoutCnt;
  logic [7:0]       lastLen;
  logic             busy;

  cc_countdatachk #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .sdi_clk       (sdi_clk),
    .Reset         (Reset),
    .fa_evr_trig   (fa_evr_trig),
    .expCount      (expCount),
    .timeoutCycles (timeoutCycles),
    .RxDataValid   (RxDataValid),
    .RxCountData   (RxCountData),
    .RxBpmPosData  (RxBpmPosData),
    .RxPosX        (RxPosX),
    .RxPosY        (RxPosY),
    .PosValid      (PosValid),
    .FrameDone     (FrameDone),
    .FrameErr      (FrameErr),
    .frameCnt      (frameCnt),
    .seqErrCnt     (seqErrCnt),
    .lenErrCnt     (lenErrCnt),
    .timeoutCnt    (timeoutCnt),
    .lastLen       (lastLen),
    .busy          (busy)
  );

  always #5 sdi_clk = ~sdi_clk;

  int cyc = 0;
  always @(posedge sdi_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] x;
    logic [31:0] y;
  } pos_exp_t;

  typedef struct {
    int   c;
    logic err;
  } frm_exp_t;

  pos_exp_t pos_q[$];
  frm_exp_t frm_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sdi_clk);
    #1;
  endtask

  // Monitor: compare every DUT pulse against the head of the matching queue.
  always @(negedge sdi_clk) begin
    if (!Reset) begin
      if (PosValid) begin
        chk("pos_expected", 32'(pos_q.size() > 0), 32'd1);
        if (pos_q.size() > 0) begin
          pos_exp_t e;
          e = pos_q.pop_front();
          chk("pos_cycle", cyc, e.c);
          chk("pos_x", RxPosX, e.x);
          chk("pos_y", RxPosY, e.y);
        end
      end
      if (FrameDone) begin
        chk("frame_expected", 32'(frm_q.size() > 0), 32'd1);
        if (frm_q.size() > 0) begin
          frm_exp_t f;
          f = frm_q.pop_front();
          chk("frame_cycle", cyc, f.c);
          chk("frame_err", FrameErr, f.err);
        end
      end
    end
  end

  // One burst: word k counts cnt0+step*k (bad_val at bad_idx); X/Y at words 0/1.
  task automatic burst(input bit do_trig, input int n, input logic [31:0] cnt0, input int step,
                       input int bad_idx, input logic [31:0] bad_val,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit exp_err, input int abort_at);
    logic [31:0] w;
    if (do_trig) begin
      fa_evr_trig = 1'b1;
      tick();
      fa_evr_trig = 1'b0;
      chk("busy_in_frame", busy, 1);
    end
    for (int k = 0; k < n; k++) begin
      w = cnt0 + 32'(step * k);
      if (k == bad_idx) w = bad_val;
      RxDataValid  = 1'b1;
      RxCountData  = w;
      RxBpmPosData = (k == 0) ? x : (k == 1) ? y : (32'hDEAD0000 + 32'(k));
      if (k == abort_at) begin
        fa_evr_trig = 1'b1;
        frm_q.push_back('{cyc + 1, 1'b1});
        tick();
        fa_evr_trig = 1'b0;
        RxDataValid = 1'b0;
        return;
      end
      if (k == 1) pos_q.push_back('{cyc + 1, x, y});
      tick();
    end
    RxDataValid = 1'b0;
    frm_q.push_back('{cyc + 1, exp_err});
    tick();
    repeat (3) tick();
  endtask

  initial begin
    Reset         = 1'b1;
    fa_evr_trig   = 1'b0;
    expCount      = 8'd0;
    timeoutCycles = 16'd1000;
    RxDataValid   = 1'b0;
    RxCountData   = '0;
    RxBpmPosData  = '0;
    repeat (3) tick();

    chk("rst_frameCnt", frameCnt, 0);
    chk("rst_seqErr", 32'(seqErrCnt), 0);
    chk("rst_lenErr", 32'(lenErrCnt), 0);
    chk("rst_timeout", 32'(timeoutCnt), 0);
    chk("rst_lastLen", 32'(lastLen), 0);
    chk("rst_posx", RxPosX, 0);
    chk("rst_posy", RxPosY, 0);
    chk("rst_pulses", {29'd0, PosValid, FrameDone, FrameErr}, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b0;
    tick();

    // Words while idle are ignored.
    RxDataValid = 1'b1;
    RxCountData = 32'd7;
    repeat (3) tick();
    RxDataValid = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_lenErr", 32'(lenErrCnt), 0);

    // Clean 14-word frame.
    expCount = 8'd14;
    burst(1, 14, 32'd100, 1, -1, 0, 32'h11, 32'h22, 1'b0, -1);
    chk("f1_lastLen", 32'(lastLen), 14);
    chk("f1_frameCnt", frameCnt, 1);
    chk("f1_lenErr", 32'(lenErrCnt), 0);
    chk("f1_seqErr", 32'(seqErrCnt), 0);
    chk("f1_busy", busy, 0);

    // Count wrap is legal.
    expCount = 8'd0;
    burst(1, 4, 32'hFFFF_FFFE, 1, -1, 0, 32'h33, 32'h44, 1'b0, -1);
    chk("f2_seqErr", 32'(seqErrCnt), 0);
    chk("f2_lastLen", 32'(lastLen), 4);

    // Word 3 = 5 instead of 3.
    burst(1, 4, 32'd0, 1, 3, 32'd5, 32'h12, 32'h34, SEQ_EN, -1);
    chk("f3_seqErr", 32'(seqErrCnt), SEQ_EN ? 1 : 0);
    chk("f3_frameCnt", frameCnt, 3);

    // Short frame: 12 of 14.
    expCount = 8'd14;
    burst(1, 12, 32'd200, 1, -1, 0, 32'h56, 32'h78, 1'b1, -1);
    chk("f4_lenErr", 32'(lenErrCnt), 1);
    chk("f4_lastLen", 32'(lastLen), 12);

    // Timeout after 50 idle WAIT cycles.
    expCount      = 8'd0;
    timeoutCycles = 16'd50;
    fa_evr_trig   = 1'b1;
    frm_q.push_back('{cyc + 52, 1'b1});
    tick();
    fa_evr_trig = 1'b0;
    repeat (55) tick();
    chk("to50_timeoutCnt", 32'(timeoutCnt), 1);
    chk("to50_frameCnt", frameCnt, 5);
    chk("to50_lastLen", 32'(lastLen), 0);

    // Timeout of 0 fires on the first WAIT cycle.
    timeoutCycles = 16'd0;
    fa_evr_trig   = 1'b1;
    frm_q.push_back('{cyc + 2, 1'b1});
    tick();
    fa_evr_trig = 1'b0;
    repeat (4) tick();
    chk("to0_timeoutCnt", 32'(timeoutCnt), 2);
    chk("to0_frameCnt", frameCnt, 6);
    timeoutCycles = 16'd1000;

    // Retrigger at word 5 aborts; the following burst is a clean new frame.
    burst(1, 8, 32'd300, 1, -1, 0, 32'h55, 32'h66, 1'b0, 5);
    chk("abort_lenErr", 32'(lenErrCnt), 2);
    burst(0, 3, 32'd400, 1, -1, 0, 32'h77, 32'h88, 1'b0, -1);
    chk("post_abort_lastLen", 32'(lastLen), 3);
    chk("post_abort_posx", RxPosX, 32'h77);
    chk("post_abort_lenErr", 32'(lenErrCnt), 2);

    // Single word: no position update, length error with expCount 2.
    expCount = 8'd2;
    burst(1, 1, 32'd500, 1, -1, 0, 32'h99, 32'hAA, 1'b1, -1);
    chk("one_word_lenErr", 32'(lenErrCnt), 3);
    chk("one_word_posx", RxPosX, 32'h77);
    chk("one_word_posy", RxPosY, 32'h88);
    chk("one_word_lastLen", 32'(lastLen), 1);

    // 19 bad words push seqErrCnt past all-ones.
    expCount = 8'd0;
    burst(1, 20, 32'd0, 0, -1, 0, 32'hAB, 32'hCD, SEQ_EN, -1);
    chk("sat_seqErr", 32'(seqErrCnt), SEQ_EN ? 15 : 0);
    chk("sat_lastLen", 32'(lastLen), 20);

    chk("pos_q_left", pos_q.size(), 0);
    chk("frame_q_left", frm_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
